// File: rtl/seg_disp_pkg.sv
// rtl/seg_disp_pkg.sv - shared code/segment constants for the scanned 7-segment display
package seg_disp_pkg;

  localparam logic [3:0] CODE_P     = 4'hA;
  localparam logic [3:0] CODE_A     = 4'hB;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low g..a patterns
  localparam logic [6:0] SEG7_0     = 7'b1000000;
  localparam logic [6:0] SEG7_1     = 7'b1111001;
  localparam logic [6:0] SEG7_2     = 7'b0100100;
  localparam logic [6:0] SEG7_3     = 7'b0110000;
  localparam logic [6:0] SEG7_4     = 7'b0011001;
  localparam logic [6:0] SEG7_5     = 7'b0010010;
  localparam logic [6:0] SEG7_6     = 7'b0000010;
  localparam logic [6:0] SEG7_7     = 7'b1111000;
  localparam logic [6:0] SEG7_8     = 7'b0000000;
  localparam logic [6:0] SEG7_9     = 7'b0010000;
  localparam logic [6:0] SEG7_P     = 7'b0001100;
  localparam logic [6:0] SEG7_A     = 7'b0001000;
  localparam logic [6:0] SEG7_BLANK = 7'b1111111;

endpackage

// File: rtl/seg_scan_display_if.sv
// rtl/seg_scan_display_if.sv - load/brightness inputs and pin outputs of the scan display
interface seg_scan_display_if #(
  parameter int NDIG = 8
);
  logic [4*NDIG-1:0] uCodes;
  logic [NDIG-1:0]   uDp;
  logic [NDIG-1:0]   uBlink;
  logic              uLoad;
  logic [2:0]        uBright;
  logic [7:0]        ySEG_;
  logic [NDIG-1:0]   yAN_;
  logic              yPending;
  logic              yFrame;

  modport master (
    output uCodes, uDp, uBlink, uLoad, uBright,
    input  ySEG_, yAN_, yPending, yFrame
  );

  modport slave (
    input  uCodes, uDp, uBlink, uLoad, uBright,
    output ySEG_, yAN_, yPending, yFrame
  );
endinterface

// File: rtl/seg_decode.sv
// rtl/seg_decode.sv - 4-bit display code to active-low 7-segment pattern
module seg_decode
  import seg_disp_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG7_BLANK;
    case (code)
      4'h0:    seg = SEG7_0;
      4'h1:    seg = SEG7_1;
      4'h2:    seg = SEG7_2;
      4'h3:    seg = SEG7_3;
      4'h4:    seg = SEG7_4;
      4'h5:    seg = SEG7_5;
      4'h6:    seg = SEG7_6;
      4'h7:    seg = SEG7_7;
      4'h8:    seg = SEG7_8;
      4'h9:    seg = SEG7_9;
      CODE_P:  seg = SEG7_P;
      CODE_A:  seg = SEG7_A;
      default: seg = SEG7_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - multiplexed common-anode 7-segment driver with shadow buffer, blink and brightness
module seg_scan_display
  import seg_disp_pkg::*;
#(
  parameter int NDIG         = 8,
  parameter int DIV          = 4,
  parameter int BLINK_FRAMES = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  seg_scan_display_if.slave  bus
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DW = $clog2(NDIG);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] P_LAST  = PW'(DIV - 1);
  localparam logic [DW-1:0] D_LAST  = DW'(NDIG - 1);
  localparam logic [BW-1:0] BC_LAST = BW'(BLINK_FRAMES - 1);

  logic [PW-1:0]     p;
  logic [2:0]        ph;
  logic [DW-1:0]     d;
  logic [BW-1:0]     bc;
  logic              bs;
  logic              pending;
  logic [4*NDIG-1:0] shCodes, acCodes;
  logic [NDIG-1:0]   shDp, acDp, shBlink, acBlink;
  logic              wrapQ;
  logic [7:0]        segQ;
  logic [NDIG-1:0]   anQ;
  logic              frameQ;

  logic              pEnd, phEnd, dWrap;
  logic [3:0]        curCode;
  logic [6:0]        curSeg;
  logic [7:0]        segNext;
  logic [NDIG-1:0]   anNext;

  assign pEnd  = (p == P_LAST);
  assign phEnd = pEnd && (ph == 3'd7);
  assign dWrap = phEnd && (d == D_LAST);

  assign curCode = acCodes[{d, 2'b00} +: 4];

  seg_decode uDecode (
    .code (curCode),
    .seg  (curSeg)
  );

  // A fully dark digit also keeps its anode off so blanked slots never ghost.
  always_comb begin
    segNext = (acBlink[d] && bs) ? SEG_OFF : {~acDp[d], curSeg};
    anNext  = '1;
    if ((ph <= bus.uBright) && (segNext != SEG_OFF)) begin
      anNext[d] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p       <= '0;
      ph      <= '0;
      d       <= '0;
      bc      <= '0;
      bs      <= 1'b0;
      pending <= 1'b0;
      shCodes <= {NDIG{CODE_BLANK}};
      acCodes <= {NDIG{CODE_BLANK}};
      shDp    <= '0;
      acDp    <= '0;
      shBlink <= '0;
      acBlink <= '0;
      wrapQ   <= 1'b0;
      segQ    <= SEG_OFF;
      anQ     <= '1;
      frameQ  <= 1'b0;
    end else begin
      p <= pEnd ? '0 : p + 1'b1;
      if (pEnd) begin
        ph <= ph + 3'd1;
      end
      if (phEnd) begin
        d <= (d == D_LAST) ? '0 : d + 1'b1;
      end
      if (dWrap) begin
        bc <= (bc == BC_LAST) ? '0 : bc + 1'b1;
        if (bc == BC_LAST) begin
          bs <= ~bs;
        end
      end

      // Copy on wrap sees the old shadow even when a load lands in the same cycle.
      if (dWrap && pending) begin
        acCodes <= shCodes;
        acDp    <= shDp;
        acBlink <= shBlink;
      end
      if (bus.uLoad) begin
        shCodes <= bus.uCodes;
        shDp    <= bus.uDp;
        shBlink <= bus.uBlink;
        pending <= 1'b1;
      end else if (dWrap) begin
        pending <= 1'b0;
      end

      wrapQ  <= dWrap;
      frameQ <= wrapQ;
      segQ   <= segNext;
      anQ    <= anNext;
    end
  end

  assign bus.ySEG_    = segQ;
  assign bus.yAN_     = anQ;
  assign bus.yPending = pending;
  assign bus.yFrame   = frameQ;

endmodule

// File: tb/tb_seg_scan_display.sv
// tb/tb_seg_scan_display.sv - directed bench for seg_scan_display (NDIG=4, DIV=2, BLINK_FRAMES=2)
module tb_seg_scan_display;

  localparam int NDIG  = 4;
  localparam int DIV   = 2;
  localparam int BF    = 2;
  localparam int SLOT  = 8 * DIV;
  localparam int FRAME = NDIG * SLOT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  seg_scan_display_if #(.NDIG(NDIG)) bus ();

  seg_scan_display #(
    .NDIG         (NDIG),
    .DIV          (DIV),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;
  int edgeN   = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s at edge %0d: got %h expected %h", tag, edgeN, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edgeN++;
  endtask

  task automatic tickTo(input int n);
    while (edgeN < n) tick();
  endtask

  task automatic load(input logic [15:0] codes, input logic [3:0] dp, input logic [3:0] blink);
    bus.uCodes = codes;
    bus.uDp    = dp;
    bus.uBlink = blink;
    bus.uLoad  = 1'b1;
    tick();
    bus.uLoad  = 1'b0;
  endtask

  task automatic checkReset(input string tag);
    checkVal({tag, "_seg"},   bus.ySEG_,    8'hFF);
    checkVal({tag, "_an"},    bus.yAN_,     4'hF);
    checkVal({tag, "_pend"},  bus.yPending, 0);
    checkVal({tag, "_frame"}, bus.yFrame,   0);
  endtask

  // First frame after release: dark, and no yFrame until clock FRAME+1.
  task automatic checkFirstFrame();
    for (int i = 0; i < FRAME; i++) begin
      tick();
      checkVal("boot_seg",   bus.ySEG_,  8'hFF);
      checkVal("boot_an",    bus.yAN_,   4'hF);
      checkVal("boot_frame", bus.yFrame, 0);
    end
  endtask

  // segs holds the expected ySEG_ per digit, digit 0 in the low byte.
  task automatic checkFrame(input string tag, input logic [31:0] segs,
                            input logic [3:0] blink, input logic [2:0] bright);
    logic [7:0] expSeg;
    logic [3:0] expAn;
    int dig, ph, f;
    while (edgeN % FRAME != 0) tick();
    for (int i = 0; i < FRAME; i++) begin
      tick();
      dig = i / SLOT;
      ph  = (i % SLOT) / DIV;
      f   = (edgeN - 1) / FRAME;
      expSeg = (blink[dig] && ((f / BF) % 2 == 1)) ? 8'hFF : segs[8*dig +: 8];
      expAn  = 4'hF;
      if (ph <= int'(bright) && expSeg != 8'hFF) expAn[dig] = 1'b0;
      checkVal({tag, "_seg"},   bus.ySEG_,  expSeg);
      checkVal({tag, "_an"},    bus.yAN_,   expAn);
      checkVal({tag, "_frame"}, bus.yFrame, (i == 0) ? 1 : 0);
    end
  endtask

  initial begin
    bus.uCodes  = '0;
    bus.uDp     = '0;
    bus.uBlink  = '0;
    bus.uLoad   = 1'b0;
    bus.uBright = 3'd7;

    repeat (3) tick();
    checkReset("rst");

    rst_n = 1'b1;
    edgeN = 0;
    checkFirstFrame();
    checkFrame("idle", 32'hFFFFFFFF, 4'b0000, 3'd7);

    load(16'h4321, 4'b0000, 4'b0000);
    checkVal("pend_rise", bus.yPending, 1);
    tickTo(3*FRAME - 1);
    checkVal("pend_hold", bus.yPending, 1);
    tick();
    checkVal("pend_fall", bus.yPending, 0);
    checkFrame("b7", 32'h99B0A4F9, 4'b0000, 3'd7);
    bus.uBright = 3'd0;
    checkFrame("b0", 32'h99B0A4F9, 4'b0000, 3'd0);
    bus.uBright = 3'd3;
    checkFrame("b3", 32'h99B0A4F9, 4'b0000, 3'd3);
    bus.uBright = 3'd7;

    load(16'hBA00, 4'b0100, 4'b0010);
    repeat (4) checkFrame("blink", 32'h880CC0C0, 4'b0010, 3'd7);

    load(16'h5678, 4'b0000, 4'b0000);
    tickTo(12*FRAME - 1);
    load(16'h0987, 4'b0000, 4'b0000);
    checkVal("pend_wrap", bus.yPending, 1);
    checkFrame("old", 32'h9282F880, 4'b0000, 3'd7);
    checkVal("pend_clr", bus.yPending, 0);
    checkFrame("new", 32'hC09080F8, 4'b0000, 3'd7);

    load(16'h1111, 4'b1111, 4'b0000);
    checkVal("pend_pre", bus.yPending, 1);
    tickTo(edgeN + 8);
    rst_n = 1'b0;
    tick();
    checkReset("midrst");
    rst_n = 1'b1;
    edgeN = 0;
    checkFirstFrame();
    checkFrame("post", 32'hFFFFFFFF, 4'b0000, 3'd7);
    checkVal("post_pend", bus.yPending, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
